store_write_buffer: RTL and testbench
=====================================

# store_write_buffer

Posted-write buffer between the core's data memory interface and the external data memory port. Stores are queued and retire in one cycle while the buffer has space. Queued stores drain to memory in the background, in program order. Loads are ordered correctly against queued stores, and a load waits until its read data has been returned.

## Interface
- `DEPTH`, 4: number of queued store entries; power of two, ≥2.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  1  core access request; held stable while `busy`=1.
- `write`  in  1  1 = store, 0 = load.
- `addr`  in  32  byte address; bits [1:0] ignored (word aligned).
- `wdata`  in  32  store data.
- `byte_en`  in  4  store byte lanes.
- `rdata`  out  32  load data; valid when `req`&~`write`&~`busy`.
- `busy`  out  1  access not complete this cycle.
- `mem_req`  out  1  memory transaction request.
- `mem_write`  out  1  1 = write transaction.
- `mem_addr`  out  32  word address, with [1:0]=0.
- `mem_wdata`  out  32  write data.
- `mem_be`  out  4  write byte lanes.
- `mem_ready`  in  1  transaction done; read data valid this cycle.
- `mem_rdata`  in  32  read data.

## Operation
- The FIFO holds entries of {word addr[31:2], data, byte_en}, with `head`, `tail`, and `count` in 0..DEPTH. Pointers wrap modulo DEPTH.
- Store accept: `req`&`write`&(`count`<DEPTH) gives `busy`=0 that cycle, and the entry is pushed at the edge. `full` is sampled at the start of the cycle. A store that arrives while full stalls, even if a drain completes in the same cycle. When a push and a pop happen in the same cycle, `count` is unchanged.
- The memory port FSM has states M_IDLE, M_WRITE, M_READ, M_RESP.
  - M_IDLE→M_READ when a load is eligible (read has priority over draining).
  - Otherwise M_IDLE→M_WRITE when `count`>0, presenting the head entry.
  - M_WRITE→M_IDLE on `mem_ready`, which pops the head.
  - M_READ→M_RESP on `mem_ready`, which captures `mem_rdata` into `rdata_q`.
  - M_RESP→M_IDLE always. In M_RESP, `busy`=0 and `rdata`=`rdata_q`.
- Memory handshake:
  - `mem_req` and its fields are registered and held stable until the cycle `mem_req`&`mem_ready`.
  - `mem_req` is 0 for at least one cycle (M_IDLE or M_RESP) between transactions.
- Load eligibility: see Configuration. A load that is not eligible waits with `busy`=1 while the buffer drains.
- Load-hit detection compares addr[31:2] with every valid entry. The youngest match wins.
- `busy` is 1 for any load except in M_RESP. It is 0 when `req`=0.
- Reset outputs: `mem_req`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, `rdata`=0, `busy`=0 (with `req`=0). Also `count`=0, `head`=`tail`=0, FSM=M_IDLE.
- Reset mid-transaction: reset deasserts `mem_req` the next cycle and discards queued stores. The memory side must tolerate an abandoned request.

## Timing
- Store latency to the core is 0 stall cycles when not full.
- Load miss with an empty buffer:
  - cycle 0: `req` seen, `busy`=1.
  - cycle 1: `mem_req`=1.
  - cycle 1+k: `mem_ready` arrives.
  - cycle 2+k: `busy`=0 and `rdata` valid.
- A drain write occupies 1+k cycles plus 1 idle cycle.
- A store pushed in cycle n is first visible on `mem_req` no earlier than cycle n+2.

## Configuration
- `WRITE_BUFFER_FORWARD_EN` defined:
  - Full hit (youngest match has `byte_en`=4'b1111): the load is serviced from the buffer with no memory read. `rdata_q` is loaded with the entry's data, the FSM goes to M_RESP next cycle, and `busy`=0 there (1-cycle stall).
  - Partial hit: the load waits until the matching entries have drained, then reads memory.
  - No hit: the load is eligible immediately and bypasses queued stores.
- `WRITE_BUFFER_FORWARD_EN` undefined: a load is eligible only when `count`=0. Every load reads memory after a full drain.

## Test plan
- Reset with `reset`=0 for 2 cycles → all outputs 0, and `count`=0.
- DEPTH=4, `mem_ready` held 0, 5 back-to-back stores → stores 1–4 have `busy`=0; store 5 has `busy`=1 until the first write completes after `mem_ready` is raised, then it is accepted.
- Stores to 0x100 (0x11111111, be 1111) and 0x104 (0x22222222, be 0011), `mem_ready`=1 → two writes on the memory port in order, with matching `mem_addr`, `mem_wdata`, and `mem_be`.
- Forward build: store 0x200=0xDEADBEEF (be 1111), then load 0x200 → `rdata`=0xDEADBEEF with no `mem_req` read, after 1 stall cycle. Non-forward build → write to 0x200 completes first, then the read returns memory data.
- Load 0x300 on an empty buffer, `mem_ready` after 3 cycles, `mem_rdata`=0xCAFEF00D → `busy` drops 5 cycles after the request, with `rdata`=0xCAFEF00D.
- `reset` asserted while in M_WRITE with 2 entries queued → `mem_req`=0 next cycle, `count`=0, and no further writes.

Source files
------------

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted store queue between core and data memory.
// Stores retire at once while space remains; queued entries drain in
// program order; loads are ordered against queued stores.
// Ports: clk, reset (sync, active-low); core side req/write/addr/
//   wdata/byte_en in, rdata/busy out; memory side mem_req/mem_write/
//   mem_addr/mem_wdata/mem_be out, mem_ready/mem_rdata in.
// Build option: WRITE_BUFFER_FORWARD_EN enables store-to-load forwarding.
module store_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        M_IDLE,
        M_WRITE,
        M_READ,
        M_RESP
    } state_t;

    state_t        r_state;
    logic [29:0]   r_fa [DEPTH];
    logic [31:0]   r_fd [DEPTH];
    logic [3:0]    r_fb [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_mem_req;
    logic          r_mem_write;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_be;
    logic [31:0]   r_rdata_q;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_rd_go;
    logic          w_fwd_go;
    logic          w_busy;
    logic [31:0]   w_fwd_data;
    logic [1:0]    w_unused_addr;

    assign w_unused_addr = addr[1:0];

    // Full is judged on the count at the start of the cycle, so a
    // store stalls even when a drain completes in the same cycle.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_push = req & write & ~w_full;
    assign w_pop  = (r_state == M_WRITE) & mem_ready;
    assign w_load = req & ~write;

`ifdef WRITE_BUFFER_FORWARD_EN
    logic w_hit;
    logic w_hit_full;

    // Walk valid entries oldest to youngest; the last match wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_full = 1'b0;
        w_fwd_data = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if ((CW'(j) < r_count) &&
                (r_fa[AW'(r_head + AW'(j))] == addr[31:2])) begin
                w_hit      = 1'b1;
                w_hit_full = (r_fb[AW'(r_head + AW'(j))] == 4'hF);
                w_fwd_data = r_fd[AW'(r_head + AW'(j))];
            end
        end
    end

    // A partial hit starts neither path and waits for the drain.
    assign w_rd_go  = w_load & ~w_hit;
    assign w_fwd_go = w_load & w_hit & w_hit_full;
`else
    assign w_rd_go    = w_load & (r_count == '0);
    assign w_fwd_go   = 1'b0;
    assign w_fwd_data = '0;
`endif

    always_comb begin
        w_busy = 1'b0;
        if (req) begin
            w_busy = write ? w_full : (r_state != M_RESP);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fa[r_tail] <= addr[31:2];
            r_fd[r_tail] <= wdata;
            r_fb[r_tail] <= byte_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= M_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_rdata_q   <= '0;
        end else begin
            case (r_state)
                M_IDLE: begin
                    if (w_rd_go) begin
                        r_state     <= M_READ;
                        r_mem_req   <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= {addr[31:2], 2'b00};
                        r_mem_wdata <= '0;
                        r_mem_be    <= '0;
                    end else if (w_fwd_go) begin
                        r_state   <= M_RESP;
                        r_rdata_q <= w_fwd_data;
                    end else if (r_count != '0) begin
                        r_state     <= M_WRITE;
                        r_mem_req   <= 1'b1;
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= {r_fa[r_head], 2'b00};
                        r_mem_wdata <= r_fd[r_head];
                        r_mem_be    <= r_fb[r_head];
                    end
                end
                M_WRITE: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= M_IDLE;
                    end
                end
                M_READ: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_rdata_q <= mem_rdata;
                        r_state   <= M_RESP;
                    end
                end
                M_RESP: r_state <= M_IDLE;
                default: r_state <= M_IDLE;
            endcase
        end
    end

    assign rdata     = r_rdata_q;
    assign busy      = w_busy;
    assign mem_req   = r_mem_req;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: scoreboard bench for store_write_buffer.
// Architectural memory model predicts load data and write order.
module tb_store_write_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic [31:0] rdata;
    logic        busy;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    store_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req(req), .write(write),
        .addr(addr), .wdata(wdata), .byte_en(byte_en),
        .rdata(rdata), .busy(busy),
        .mem_req(mem_req), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    wr_t         exp_wq[$];
    logic [31:0] exp_rq[$];
    logic [31:0] arch [logic [29:0]];
    logic [31:0] phys [logic [29:0]];

    int   checks = 0;
    int   errors = 0;
    int   writes_seen = 0;
    int   reads_seen = 0;
    int   mode = 0;
    logic man_ready = 1'b0;

    function automatic logic [31:0] init_word(input logic [29:0] w);
        if (w == 30'h0C0) return 32'hCAFEF00D;
        return {w[15:0] ^ 16'h5A5A, ~w[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
        input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        if (arch.exists(a[31:2])) return arch[a[31:2]];
        return init_word(a[31:2]);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        if (phys.exists(a[31:2])) return phys[a[31:2]];
        return init_word(a[31:2]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
        input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Memory responder: ready pattern per mode, data from phys.
    always @(posedge clk) begin
        #2;
        case (mode)
            0: mem_ready = 1'b0;
            1: mem_ready = 1'b1;
            2: mem_ready = 1'($urandom_range(0, 1));
            default: mem_ready = man_ready;
        endcase
        mem_rdata = mem_req ? phys_rd(mem_addr) : 32'h0;
    end

    // Monitor: compares DUT outputs against queued expectations.
    logic        pend = 1'b0;
    logic        p_w;
    logic [31:0] p_a;
    logic [31:0] p_d;
    logic [3:0]  p_be;
    always @(negedge clk) begin
        wr_t e;
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("hold_req", 32'(mem_req), 32'd1);
                chk("hold_write", 32'(mem_write), 32'(p_w));
                chk("hold_addr", mem_addr, p_a);
                chk("hold_wdata", mem_wdata, p_d);
                chk("hold_be", 32'(mem_be), 32'(p_be));
            end
            if (mem_req && mem_ready) begin
                if (mem_write) begin
                    writes_seen++;
                    checks++;
                    if (exp_wq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write addr=%h", mem_addr);
                    end else begin
                        e = exp_wq.pop_front();
                        chk("wr_addr", mem_addr, e.a);
                        chk("wr_data", mem_wdata, e.d);
                        chk("wr_be", 32'(mem_be), 32'(e.be));
                    end
                    phys[mem_addr[31:2]] =
                        merge(phys_rd(mem_addr), mem_wdata, mem_be);
                end else begin
                    reads_seen++;
                end
            end
            if (req && !write && !busy) begin
                checks++;
                if (exp_rq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load rdata=%h", rdata);
                end else begin
                    chk("load_rdata", rdata, exp_rq.pop_front());
                end
            end
            pend = mem_req && !mem_ready;
            p_w  = mem_write;
            p_a  = mem_addr;
            p_d  = mem_wdata;
            p_be = mem_be;
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
        input logic [3:0] be, output int stalls);
        wr_t e;
        stalls = 0;
        req = 1'b1; write = 1'b1; addr = a; wdata = d; byte_en = be;
        arch[a[31:2]] = merge(arch_rd(a), d, be);
        e.a = {a[31:2], 2'b00}; e.d = d; e.be = be;
        exp_wq.push_back(e);
        forever begin
            @(negedge clk);
            if (!busy) break;
            stalls++;
            if (stalls > 300) begin
                errors++;
                $display("FAIL store_timeout addr=%h busy=%b", a, busy);
                break;
            end
        end
        @(posedge clk); #1;
        req = 1'b0; write = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output int stalls);
        stalls = 0;
        req = 1'b1; write = 1'b0; addr = a;
        exp_rq.push_back(arch_rd(a));
        forever begin
            @(negedge clk);
            if (!busy) break;
            stalls++;
            if (stalls > 300) begin
                errors++;
                $display("FAIL load_timeout addr=%h busy=%b", a, busy);
                break;
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        mode = 1;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_wq.size() == 0 && !mem_req) break;
            n++;
            if (n > 500) begin
                errors++;
                $display("FAIL drain_timeout pending=%0d", exp_wq.size());
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int w0;
        int r0;
        logic [31:0] a;
        reset = 1'b0; req = 1'b0; write = 1'b0;
        addr = '0; wdata = '0; byte_en = '0;
        mode = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(dut.r_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Fill to DEPTH with memory stalled, then one more store
        mode = 3; man_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            do_store(32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i),
                4'hF, st);
            chk("fill_no_stall", 32'(st), 32'd0);
        end
        req = 1'b1; write = 1'b1; addr = 32'h1010;
        wdata = 32'hA0000004; byte_en = 4'hF;
        arch[30'h404] = merge(arch_rd(32'h1010), wdata, byte_en);
        exp_wq.push_back('{a: 32'h1010, d: 32'hA0000004, be: 4'hF});
        @(negedge clk);
        chk("full_stall", 32'(busy), 32'd1);
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("full_hold", 32'(busy), 32'd1);
        end
        @(posedge clk); #1 man_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_cycle", 32'(busy), 32'd1);
        @(posedge clk); #1 man_ready = 1'b0;
        @(negedge clk);
        chk("full_accept", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req = 1'b0; write = 1'b0;
        wait_idle();

        // Two stores drain in order
        w0 = writes_seen;
        do_store(32'h100, 32'h11111111, 4'b1111, st);
        do_store(32'h104, 32'h22222222, 4'b0011, st);
        wait_idle();
        chk("two_writes", 32'(writes_seen - w0), 32'd2);

        // Store then load same word
        r0 = reads_seen;
        do_store(32'h200, 32'hDEADBEEF, 4'hF, st);
        do_load(32'h200, st);
`ifdef WRITE_BUFFER_FORWARD_EN
        chk("fwd_stall", 32'(st), 32'd1);
        chk("fwd_no_read", 32'(reads_seen - r0), 32'd0);
`else
        chk("nofwd_stall", 32'(st), 32'd4);
        chk("nofwd_read", 32'(reads_seen - r0), 32'd1);
`endif
        wait_idle();

        // Load miss timing on an empty buffer
        mode = 3; man_ready = 1'b0;
        @(posedge clk); #1;
        fork
            do_load(32'h300, st);
            begin
                @(posedge clk); @(negedge clk);
                chk("miss_mem_req", 32'(mem_req), 32'd1);
                chk("miss_mem_addr", mem_addr, 32'h300);
                repeat (3) @(posedge clk);
                #1 man_ready = 1'b1;
                @(posedge clk);
                #1 man_ready = 1'b0;
            end
        join
        chk("miss_stall", 32'(st), 32'd5);
        wait_idle();

        // Reset while a write is outstanding
        mode = 0;
        w0 = writes_seen;
        do_store(32'h800, 32'h88888888, 4'hF, st);
        do_store(32'h804, 32'h99999999, 4'hF, st);
        @(negedge clk);
        chk("rst_pre_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        exp_wq.delete();
        arch.delete(30'h200);
        arch.delete(30'h201);
        mode = 1;
        @(negedge clk);
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_count", 32'(dut.r_count), 32'd0);
        repeat (10) @(negedge clk);
        chk("rst_no_writes", 32'(writes_seen - w0), 32'd0);
        chk("rst_idle_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;

        // Randomized mix on a small address window
        mode = 2;
        for (int i = 0; i < 250; i++) begin
            a = 32'h400 + 32'(4 * $urandom_range(0, 7))
                + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                do_load(a, st);
            end else begin
                do_store(a, $urandom,
                    ($urandom_range(0, 1) == 1) ? 4'hF
                        : 4'($urandom_range(1, 15)), st);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();
        chk("end_wq_empty", 32'(exp_wq.size()), 32'd0);
        chk("end_rq_empty", 32'(exp_rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
